// File: rtl/fm_hdmi_ddr_tx.sv
// HDMI transmitter video output stage.
// Converts 4:4:4 YCbCr to 4:2:2. Blanking codes replace the data outside active video.
// The data is pipelined with its syncs and driven either through per-bit DDR output
// registers (Y on the rising edge, C on the falling edge) or as a plain SDR bus.
module fm_hdmi_ddr_tx #(
    parameter int P_DW   = 8,
    parameter int P_MODE = 0,
    parameter int P_PIPE = 2,
    parameter int P_BLK  = 1
) (
    input  logic              clk_v,
    input  logic              rst,
    input  logic              i_de,
    input  logic              i_hs,
    input  logic              i_vs,
    input  logic [P_DW-1:0]   i_y,
    input  logic [P_DW-1:0]   i_cb,
    input  logic [P_DW-1:0]   i_cr,
    output logic              o_de,
    output logic              o_hs,
    output logic              o_vs,
    output logic [2*P_DW-1:0] o_d,
    output logic              o_odd_err
);

    // Blanking levels scale with the component width (video black and neutral chroma).
    localparam logic [P_DW-1:0] BLANK_Y = (P_BLK != 0) ? P_DW'(16  << (P_DW - 8)) : '0;
    localparam logic [P_DW-1:0] BLANK_C = (P_BLK != 0) ? P_DW'(128 << (P_DW - 8)) : '0;

    // Stage word layout: {de, hs, vs, Y, C}
    localparam int SW = 3 + 2 * P_DW;
    localparam logic [SW-1:0] BLANK_WORD = {3'b000, BLANK_Y, BLANK_C};

    logic [SW-1:0] stage_reg [0:P_PIPE];
    logic          phase_reg;

    logic [SW-1:0]   last_word;
    logic [P_DW-1:0] last_y;
    logic [P_DW-1:0] last_c;

    logic [15:0] cnt_reg;
    logic        de_prev_reg;
    logic        armed_reg;
    logic        err_reg;

    // Stage 0: chroma decimation (Cb on even pixels, Cr on odd pixels) and blank insertion.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            stage_reg[0] <= BLANK_WORD;
            phase_reg    <= 1'b0;
        end else begin
            phase_reg <= i_de ? ~phase_reg : 1'b0;
            if (i_de) begin
                stage_reg[0] <= {1'b1, i_hs, i_vs, i_y, (phase_reg ? i_cr : i_cb)};
            end else begin
                stage_reg[0] <= {1'b0, i_hs, i_vs, BLANK_Y, BLANK_C};
            end
        end
    end

    // Extra delay stages; syncs travel in the same word so they stay aligned with data.
    always_ff @(posedge clk_v) begin
        for (int k = 1; k <= P_PIPE; k++) begin
            if (rst) begin
                stage_reg[k] <= BLANK_WORD;
            end else begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign last_word = stage_reg[P_PIPE];
    assign last_y    = last_word[2*P_DW-1:P_DW];
    assign last_c    = last_word[P_DW-1:0];

    generate
        if (P_MODE == 0) begin : gen_ddr
            logic [2:0] sync_reg;

            // Syncs get one register to match the latency of the DDR output cells.
            always_ff @(posedge clk_v) begin
                if (rst) begin
                    sync_reg <= 3'b000;
                end else begin
                    sync_reg <= last_word[SW-1 -: 3];
                end
            end

            assign {o_de, o_hs, o_vs} = sync_reg;
            assign o_d[P_DW-1:0]      = '0;

            for (genvar gi = 0; gi < P_DW; gi++) begin : gen_oddr
                logic d1_reg;
                logic d2_reg;

                // Same-edge DDR cell: both halves captured on the rising edge.
                always_ff @(posedge clk_v) begin
                    if (rst) begin
                        d1_reg <= BLANK_Y[gi];
                        d2_reg <= BLANK_C[gi];
                    end else begin
                        d1_reg <= last_y[gi];
                        d2_reg <= last_c[gi];
                    end
                end

                // Pin shows Y while the clock is high and C while it is low.
                assign o_d[P_DW+gi] = clk_v ? d1_reg : d2_reg;
            end
        end else begin : gen_sdr
            assign {o_de, o_hs, o_vs} = last_word[SW-1 -: 3];
            assign o_d                = {last_y, last_c};
        end
    endgenerate

    // Active pixel count per line. An odd count at the end of the line sets the sticky error.
    // armed_reg stays low until de=0 has been seen after reset, so a line cut short by reset is ignored.
    always_ff @(posedge clk_v) begin
        if (rst) begin
            cnt_reg     <= 16'd0;
            de_prev_reg <= 1'b0;
            armed_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            de_prev_reg <= i_de;
            if (!i_de) begin
                armed_reg <= 1'b1;
            end
            if (i_de) begin
                if (cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end else if (de_prev_reg) begin
                cnt_reg <= 16'd0;
                if (armed_reg && cnt_reg[0]) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign o_odd_err = err_reg;

endmodule

// File: tb/tb_fm_hdmi_ddr_tx.sv
// Bench for fm_hdmi_ddr_tx. Four configurations share one stimulus stream:
//   u0 SDR pipe 2 8-bit, u1 DDR pipe 2 8-bit, u2 SDR pipe 1 no-blank, u3 SDR pipe 0 10-bit.
module tb_fm_hdmi_ddr_tx;

    logic       clk_v = 1'b0;
    logic       rst   = 1'b1;
    logic       de    = 1'b0;
    logic       hs    = 1'b0;
    logic       vs    = 1'b0;
    logic [9:0] y     = '0;
    logic [9:0] cb    = '0;
    logic [9:0] cr    = '0;

    logic        o_de0, o_hs0, o_vs0, err0;
    logic [15:0] o_d0;
    logic        o_de1, o_hs1, o_vs1, err1;
    logic [15:0] o_d1;
    logic        o_de2, o_hs2, o_vs2, err2;
    logic [15:0] o_d2;
    logic        o_de3, o_hs3, o_vs3, err3;
    logic [19:0] o_d3;

    int checks = 0;
    int errors = 0;

    always #5 clk_v = ~clk_v;

    fm_hdmi_ddr_tx #(.P_DW(8), .P_MODE(1), .P_PIPE(2), .P_BLK(1)) u0 (
        .clk_v(clk_v), .rst(rst), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_y(y[7:0]), .i_cb(cb[7:0]), .i_cr(cr[7:0]),
        .o_de(o_de0), .o_hs(o_hs0), .o_vs(o_vs0), .o_d(o_d0), .o_odd_err(err0));

    fm_hdmi_ddr_tx #(.P_DW(8), .P_MODE(0), .P_PIPE(2), .P_BLK(1)) u1 (
        .clk_v(clk_v), .rst(rst), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_y(y[7:0]), .i_cb(cb[7:0]), .i_cr(cr[7:0]),
        .o_de(o_de1), .o_hs(o_hs1), .o_vs(o_vs1), .o_d(o_d1), .o_odd_err(err1));

    fm_hdmi_ddr_tx #(.P_DW(8), .P_MODE(1), .P_PIPE(1), .P_BLK(0)) u2 (
        .clk_v(clk_v), .rst(rst), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_y(y[7:0]), .i_cb(cb[7:0]), .i_cr(cr[7:0]),
        .o_de(o_de2), .o_hs(o_hs2), .o_vs(o_vs2), .o_d(o_d2), .o_odd_err(err2));

    fm_hdmi_ddr_tx #(.P_DW(10), .P_MODE(1), .P_PIPE(0), .P_BLK(1)) u3 (
        .clk_v(clk_v), .rst(rst), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_y(y), .i_cb(cb), .i_cr(cr),
        .o_de(o_de3), .o_hs(o_hs3), .o_vs(o_vs3), .o_d(o_d3), .o_odd_err(err3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Input history per rising edge; entries at or below OFS stand for "before simulation" (in reset).
    localparam int HN  = 1024;
    localparam int OFS = 8;
    bit         h_rst [HN];
    bit         h_de  [HN];
    bit         h_hs  [HN];
    bit         h_vs  [HN];
    bit         h_odd [HN];   // pixel index within its line is odd
    logic [9:0] h_y   [HN];
    logic [9:0] h_cb  [HN];
    logic [9:0] h_cr  [HN];
    int n = OFS;

    // Line bookkeeping for the odd-count flag
    int cur_len = 0;
    bit line_ok = 1'b0;
    bit prev_de = 1'b0;
    bit m_err   = 1'b0;

    // Output word {de,hs,vs,Y,C} expected after edge n for a given latency/width/blank setting.
    function automatic logic [22:0] model(input int lat, input int dw, input bit blk);
        int s;
        logic [9:0] by, bc, msk, my, mc;
        s   = n - lat + 1;
        by  = blk ? 10'(16 << (dw - 8)) : 10'd0;
        bc  = blk ? 10'(128 << (dw - 8)) : 10'd0;
        msk = (dw == 10) ? 10'h3FF : 10'h0FF;
        if (s <= OFS) return {3'b000, by, bc};
        for (int k = s; k <= n; k++) begin
            if (h_rst[k]) return {3'b000, by, bc};
        end
        if (h_de[s]) begin
            my = h_y[s] & msk;
            mc = (h_odd[s] ? h_cr[s] : h_cb[s]) & msk;
        end else begin
            my = by;
            mc = bc;
        end
        return {h_de[s], h_hs[s], h_vs[s], my, mc};
    endfunction

    // Compare process: record the edge, advance the model, then check every output.
    always @(posedge clk_v) begin
        logic [22:0] e0, e1, e2, e3;
        n = n + 1;
        h_rst[n] = rst; h_de[n] = de; h_hs[n] = hs; h_vs[n] = vs;
        h_y[n] = y; h_cb[n] = cb; h_cr[n] = cr;
        h_odd[n] = (cur_len % 2) == 1;
        if (rst) begin
            m_err = 1'b0; cur_len = 0; line_ok = 1'b0; prev_de = 1'b0;
        end else begin
            if (de) begin
                if (cur_len < 65535) cur_len++;
            end else begin
                if (prev_de && line_ok && (cur_len % 2) == 1) m_err = 1'b1;
                cur_len = 0;
                line_ok = 1'b1;
            end
            prev_de = de;
        end
        #1;
        e0 = model(3, 8, 1'b1);
        e1 = model(4, 8, 1'b1);
        e2 = model(2, 8, 1'b0);
        e3 = model(1, 10, 1'b1);
        chk("u0_d",    32'(o_d0), 32'({e0[17:10], e0[7:0]}));
        chk("u0_sync", 32'({o_de0, o_hs0, o_vs0}), 32'(e0[22:20]));
        chk("u1_y",    32'(o_d1), 32'({e1[17:10], 8'h00}));
        chk("u1_sync", 32'({o_de1, o_hs1, o_vs1}), 32'(e1[22:20]));
        chk("u2_d",    32'(o_d2), 32'({e2[17:10], e2[7:0]}));
        chk("u2_sync", 32'({o_de2, o_hs2, o_vs2}), 32'(e2[22:20]));
        chk("u3_d",    32'(o_d3), 32'(e3[19:0]));
        chk("u3_sync", 32'({o_de3, o_hs3, o_vs3}), 32'(e3[22:20]));
        chk("odd_err", 32'({err0, err1, err2, err3}), 32'({4{m_err}}));
        @(negedge clk_v);
        #1;
        chk("u1_c",    32'(o_d1), 32'({e1[7:0], 8'h00}));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit d, input bit h, input bit v,
                         input logic [9:0] yy, input logic [9:0] bb, input logic [9:0] rr);
        @(negedge clk_v);
        rst = r; de = d; hs = h; vs = v; y = yy; cb = bb; cr = rr;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom));
        end
    endtask

    task automatic line(input int npx, input logic [9:0] y0, input logic [9:0] b0, input logic [9:0] r0);
        for (int i = 0; i < npx; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, y0 + 10'(i), b0 + 10'(i), r0 + 10'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        $display("line: %0d px, Y from %h, Cb from %h, Cr from %h", npx, y0, b0, r0);
    endtask

    initial begin
        logic [15:0] exp1 [4];
        exp1[0] = 16'h01A0; exp1[1] = 16'h02B1; exp1[2] = 16'h03A2; exp1[3] = 16'h04B3;

        // Reset: blank codes on every configuration
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        chk("rst_u0_d",  32'(o_d0), 32'h1080);
        chk("rst_u0_de", 32'(o_de0), 32'h0);
        chk("rst_u3_d",  32'(o_d3), 32'h10200);
        chk("rst_err",   32'(err0), 32'h0);
        #1;
        chk("rst_u1_lo", 32'(o_d1), 32'h8000);
        @(posedge clk_v);
        #1;
        chk("rst_u1_hi", 32'(o_d1), 32'h1000);
        idle(2);
        $display("reset released");

        // 4-px line: co-sited Cb, decimated Cr, three cycles of latency on u0
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b0, 1'b1, 1'b0, 1'b0, 10'(i + 1), 10'(8'hA0 + i), 10'(8'hB0 + i));
            else       drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
            if (i >= 3) chk("line4_u0", 32'(o_d0), 32'(exp1[i-3]));
        end
        idle(3);
        chk("even_err", 32'(err0), 32'h0);
        $display("line: 4 px, Y 01..04");

        // Odd line sets the sticky flag; a later even line leaves it set
        line(5, 10'h20, 10'h40, 10'h60);
        idle(2);
        chk("odd_err_set", 32'(err0), 32'h1);
        line(4, 10'h30, 10'h50, 10'h70);
        idle(2);
        chk("odd_err_sticky", 32'(err0), 32'h1);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        chk("odd_err_rst", 32'(err0), 32'h0);
        idle(2);
        $display("sticky error cleared by reset");

        // Blanking with random data and sync toggles
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, (i % 3) == 0, (i % 5) == 0, 10'($urandom), 10'($urandom), 10'($urandom));
        end
        chk("blk0_u2_d", 32'(o_d2), 32'h0);
        idle(4);
        $display("blanking with sync toggles");

        // Reset on pixel 3 of an 8-px line
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h11, 10'h21, 10'h31);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h12, 10'h22, 10'h32);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 10'h13, 10'h23, 10'h33);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        chk("midrst_u0_d",  32'(o_d0), 32'h1080);
        chk("midrst_u0_de", 32'(o_de0), 32'h0);
        chk("midrst_u3_d",  32'(o_d3), 32'h10200);
        idle(2);
        line(2, 10'h44, 10'h55, 10'h66);
        idle(3);
        chk("midrst_err", 32'(err0), 32'h0);
        $display("reset mid-line");

        // 10-bit 2-px line on u3 (zero pipe stages: one cycle of latency)
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h3F0, 10'h2A5, 10'h155);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h3F1, 10'h2A6, 10'h156);
        chk("dw10_px1", 32'(o_d3), 32'hFC2A5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
        chk("dw10_px2", 32'(o_d3), 32'hFC556);
        idle(3);
        $display("line: 2 px, 10-bit");

        // Single-pixel line: Y with Cb, then blank; odd count sets the flag
        line(1, 10'h7E, 10'h9C, 10'hDB);
        idle(5);
        chk("one_px_err", 32'(err0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
